// File: rtl/ray_frame_controller_if.sv
// Interface bundling the configuration, control, pixel-handshake and status
// signals of ray_frame_controller.
//   master : drives cfg_*/ctrl_*/err_clr/pix_*, observes rt_* and status
//   slave  : the controller side (consumes cfg/ctrl/pix, produces rt/status)
interface ray_frame_controller_if #(
    parameter int unsigned CW  = 11,
    parameter int unsigned DW  = 13,
    parameter int unsigned FCW = 16
);
    // configuration
    logic [3*CW-1:0] cfg_pos;
    logic [3*CW-1:0] cfg_dir;
    logic [DW-1:0]   cfg_width;
    logic [DW-1:0]   cfg_height;
    logic            cfg_commit;
    // control
    logic            ctrl_start;
    logic            ctrl_continuous;
    logic            ctrl_abort;
    logic            err_clr;
    // tracer -> packer pixel handshake (observed only)
    logic            pix_valid;
    logic            pix_ready;
    logic            pix_sof;
    logic            pix_eol;
    // tracer configuration / hold
    logic            rt_hold;
    logic [3*CW-1:0] rt_pos;
    logic [3*CW-1:0] rt_dir;
    logic [DW-1:0]   rt_width;
    logic [DW-1:0]   rt_height;
    // status
    logic            busy;
    logic            frame_done;
    logic            aborted;
    logic [FCW-1:0]  frame_count;
    logic            err_sof;
    logic            err_eol;
    logic            err_cfg;

    modport master (
        output cfg_pos, cfg_dir, cfg_width, cfg_height, cfg_commit,
        output ctrl_start, ctrl_continuous, ctrl_abort, err_clr,
        output pix_valid, pix_ready, pix_sof, pix_eol,
        input  rt_hold, rt_pos, rt_dir, rt_width, rt_height,
        input  busy, frame_done, aborted, frame_count, err_sof, err_eol, err_cfg
    );

    modport slave (
        input  cfg_pos, cfg_dir, cfg_width, cfg_height, cfg_commit,
        input  ctrl_start, ctrl_continuous, ctrl_abort, err_clr,
        input  pix_valid, pix_ready, pix_sof, pix_eol,
        output rt_hold, rt_pos, rt_dir, rt_width, rt_height,
        output busy, frame_done, aborted, frame_count, err_sof, err_eol, err_cfg
    );
endinterface

// File: rtl/ray_frame_controller.sv
// Frame sequencer and configuration front-end for the ray tracing unit.
// Keeps shadow copies of camera position/direction and image size, applies
// them to the tracer only between frames, holds the tracer in reset while
// idle, and watches the tracer->packer pixel handshake for SOF/EOL framing.
// Ports:
//   clk    : clock (tracer/stream domain)
//   reset  : asynchronous active-high reset
//   bus    : ray_frame_controller_if.slave (cfg/ctrl/pix in, rt/status out)
module ray_frame_controller #(
    parameter int unsigned CW         = 11,
    parameter int unsigned DW         = 13,
    parameter int unsigned FCW        = 16,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned DEF_WIDTH  = 200,
    parameter int unsigned DEF_HEIGHT = 200
) (
    input logic                   clk,
    input logic                   reset,
    ray_frame_controller_if.slave bus
);
    localparam int unsigned HCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StFrameEnd} state_e;

    state_e          state_q, state_d;
    logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [DW-1:0]   x_cnt_q, x_cnt_d;
    logic [DW-1:0]   y_cnt_q, y_cnt_d;
    logic [FCW-1:0]  frame_count_q, frame_count_d;

    logic [3*CW-1:0] sh_pos_q, sh_dir_q;
    logic [DW-1:0]   sh_width_q, sh_height_q;
    logic [3*CW-1:0] rt_pos_q, rt_dir_q;
    logic [DW-1:0]   rt_width_q, rt_height_q;

    logic            rt_hold_q, busy_q, frame_done_q, aborted_q;
    logic            frame_done_d, aborted_d;
    logic            err_sof_q, err_sof_d;
    logic            err_eol_q, err_eol_d;
    logic            err_cfg_q, err_cfg_d;

    logic            load_rt;
    logic            beat, x_last, y_last;
    logic            sof_bad, eol_bad, cfg_bad;

    assign beat   = bus.pix_valid & bus.pix_ready;
    assign x_last = (x_cnt_q == rt_width_q - DW'(1));
    assign y_last = (y_cnt_q == rt_height_q - DW'(1));

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        frame_count_d = frame_count_q;
        load_rt       = 1'b0;
        frame_done_d  = 1'b0;
        aborted_d     = 1'b0;
        sof_bad       = 1'b0;
        eol_bad       = 1'b0;
        cfg_bad       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.ctrl_start && !bus.ctrl_abort) begin
                    if (sh_width_q == '0 || sh_height_q == '0) begin
                        cfg_bad = 1'b1;
                    end else begin
                        state_d = StLoad;
                        load_rt = 1'b1;
                    end
                end
            end
            StLoad: begin
                x_cnt_d = '0;
                y_cnt_d = '0;
                if (hold_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q - HCW'(1);
                end
            end
            StRun: begin
                if (beat) begin
                    sof_bad = bus.pix_sof != (x_cnt_q == '0 && y_cnt_q == '0);
                    eol_bad = bus.pix_eol != x_last;
                    // Framing errors are only flagged; counting follows beats alone.
                    if (x_last) begin
                        x_cnt_d = '0;
                        y_cnt_d = y_cnt_q + DW'(1);
                    end else begin
                        x_cnt_d = x_cnt_q + DW'(1);
                    end
                    if (x_last && y_last) begin
                        state_d = StFrameEnd;
                    end
                end
            end
            StFrameEnd: begin
                // Completion is reported on the edge leaving this state so a
                // same-cycle abort can still suppress it.
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + FCW'(1);
                if (bus.ctrl_continuous) begin
                    state_d = StLoad;
                    load_rt = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.ctrl_abort && state_q != StIdle) begin
            state_d       = StIdle;
            load_rt       = 1'b0;
            frame_done_d  = 1'b0;
            frame_count_d = frame_count_q;
            aborted_d     = 1'b1;
        end

        if (load_rt) begin
            hold_cnt_d = HCW'(RST_CYCLES - 1);
        end

        // A flag being set in the same cycle as err_clr stays set.
        err_sof_d = (err_sof_q & ~bus.err_clr) | sof_bad;
        err_eol_d = (err_eol_q & ~bus.err_clr) | eol_bad;
        err_cfg_d = (err_cfg_q & ~bus.err_clr) | cfg_bad;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            hold_cnt_q    <= '0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            frame_count_q <= '0;
            sh_pos_q      <= '0;
            sh_dir_q      <= '0;
            sh_width_q    <= DW'(DEF_WIDTH);
            sh_height_q   <= DW'(DEF_HEIGHT);
            rt_pos_q      <= '0;
            rt_dir_q      <= '0;
            rt_width_q    <= '0;
            rt_height_q   <= '0;
            rt_hold_q     <= 1'b1;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            aborted_q     <= 1'b0;
            err_sof_q     <= 1'b0;
            err_eol_q     <= 1'b0;
            err_cfg_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            frame_count_q <= frame_count_d;
            if (bus.cfg_commit) begin
                sh_pos_q    <= bus.cfg_pos;
                sh_dir_q    <= bus.cfg_dir;
                sh_width_q  <= bus.cfg_width;
                sh_height_q <= bus.cfg_height;
            end
            // Loads the pre-edge shadow, so a commit in this cycle waits a frame.
            if (load_rt) begin
                rt_pos_q    <= sh_pos_q;
                rt_dir_q    <= sh_dir_q;
                rt_width_q  <= sh_width_q;
                rt_height_q <= sh_height_q;
            end
            rt_hold_q    <= (state_d != StRun);
            busy_q       <= (state_d != StIdle);
            frame_done_q <= frame_done_d;
            aborted_q    <= aborted_d;
            err_sof_q    <= err_sof_d;
            err_eol_q    <= err_eol_d;
            err_cfg_q    <= err_cfg_d;
        end
    end

    assign bus.rt_hold     = rt_hold_q;
    assign bus.rt_pos      = rt_pos_q;
    assign bus.rt_dir      = rt_dir_q;
    assign bus.rt_width    = rt_width_q;
    assign bus.rt_height   = rt_height_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.aborted     = aborted_q;
    assign bus.frame_count = frame_count_q;
    assign bus.err_sof     = err_sof_q;
    assign bus.err_eol     = err_eol_q;
    assign bus.err_cfg     = err_cfg_q;
endmodule
